// File: rtl/fanout_fork_ctrl.sv
// ---------------------------------------------------------------------------
// fanout_fork_ctrl
//
// Eager-fork controller. One upstream valid/ready token stream is broadcast
// to up to NUM_OUT consumers. The token sits in a one-entry buffer, and a
// per-consumer "sent" bit records who has already taken it. Consumers may
// accept in different cycles, and no consumer ever sees the same token twice.
// Upstream is released only once every enabled consumer has the token.
// The enable mask can be reloaded at runtime. A reload that arrives while a
// token is held is parked until the buffer drains.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   cfg_load     one-cycle pulse that loads cfg_mask
//   cfg_mask     requested per-consumer enable mask
//   in_data      upstream token
//   in_valid     upstream valid
//   in_ready     upstream ready
//   out_data     broadcast token, shared by all consumers
//   out_valid    per-consumer valid
//   out_ready    per-consumer ready
//   active_mask  mask currently in force
//   cfg_pending  a mask load is waiting for the buffer to drain
//   busy         buffer holds a token
//   xfer_cnt     tokens fully delivered, wraps silently
// ---------------------------------------------------------------------------
module fanout_fork_ctrl #(
    parameter int NUM_OUT = 7,
    parameter int DATA_W  = 17,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [NUM_OUT-1:0] cfg_mask,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [NUM_OUT-1:0] active_mask,
    output logic               cfg_pending,
    output logic               busy,
    output logic [CNT_W-1:0]   xfer_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bufState_t;

    bufState_t          r_state;
    bufState_t          w_stateNext;
    logic [DATA_W-1:0]  r_bufData;
    logic [NUM_OUT-1:0] r_sent;
    logic [NUM_OUT-1:0] r_mask;
    logic [NUM_OUT-1:0] r_pendMask;
    logic               r_pend;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_full;
    logic [NUM_OUT-1:0] w_outValid;
    logic [NUM_OUT-1:0] w_take;
    logic               w_done;
    logic               w_inReady;
    logic               w_capture;

    // Buffer occupancy register. Reset drops any held token outright, so a
    // reset in the middle of a transfer never counts as a completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A capture in the same cycle as a completion keeps the buffer FULL.
    // This gives back-to-back throughput of one token per cycle.
    always_comb begin
        w_stateNext = r_state;
        if (w_capture) begin
            w_stateNext = FULL;
        end else if (w_done) begin
            w_stateNext = EMPTY;
        end
    end

    // Handshake decode.
    // "done" means that every enabled consumer has either taken the token
    // earlier or takes it in this cycle. Upstream stays blocked during a
    // config load cycle and while a parked load waits. This keeps the mask
    // fixed for the whole life of a token. With a zero mask an accepted
    // token is sunk: it is never captured into the buffer.
    always_comb begin
        w_full     = (r_state == FULL);
        w_outValid = {NUM_OUT{w_full}} & r_mask & ~r_sent;
        w_take     = w_outValid & out_ready;
        w_done     = w_full && ((r_mask & ~(r_sent | w_take)) == '0);
        w_inReady  = ~r_pend & ~cfg_load & (~w_full | w_done);
        w_capture  = in_valid & w_inReady & (r_mask != '0);
    end

    // Token payload and per-consumer delivery tracking.
    // A new capture clears the sent bits. Otherwise each consumer's take
    // is accumulated into its sent bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bufData <= '0;
            r_sent    <= '0;
        end else if (w_capture) begin
            r_bufData <= in_data;
            r_sent    <= '0;
        end else begin
            r_sent    <= r_sent | w_take;
        end
    end

    // Completed-token counter. It wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Mask configuration.
    // While the buffer is full, including the cycle in which it completes,
    // a load is parked in pend_mask. The last write wins. The parked mask
    // applies on the first empty cycle. A direct load in an empty cycle
    // supersedes anything still parked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask     <= '0;
            r_pend     <= 1'b0;
            r_pendMask <= '0;
        end else if (w_full) begin
            if (cfg_load) begin
                r_pend     <= 1'b1;
                r_pendMask <= cfg_mask;
            end
        end else if (cfg_load) begin
            r_mask <= cfg_mask;
            r_pend <= 1'b0;
        end else if (r_pend) begin
            r_mask <= r_pendMask;
            r_pend <= 1'b0;
        end
    end

    assign in_ready    = w_inReady;
    assign out_data    = r_bufData;
    assign out_valid   = w_outValid;
    assign active_mask = r_mask;
    assign cfg_pending = r_pend;
    assign busy        = w_full;
    assign xfer_cnt    = r_cnt;

endmodule
